mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_pkg.sv | 23 ++
 rtl/mem_addr_decode.sv | 33 +++
 rtl/mem_bus_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the CPU memory bus controller.
// Holds the FSM encoding and the peripheral-window base address.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    PERIPH,
    DONE
  } state_e;

  localparam int unsigned DEF_DATAW       = 16;
  localparam int unsigned DEF_ADDRW       = 16;
  localparam int unsigned DEF_PERIPH_BITS = 4;
  localparam int unsigned DEF_NPERIPH     = 9;
  localparam int unsigned DEF_WAIT_STATES = 1;

  // Lowest address of the peripheral window for the default widths.
  localparam logic [DEF_ADDRW-1:0] DEF_PERIPH_BASE =
    ~DEF_ADDRW'((1 << DEF_PERIPH_BITS) - 1);

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational address decode: SRAM vs. peripheral window,
// slot index and legality against the read/write masks.
module mem_addr_decode #(
  parameter int unsigned ADDRW       = 16,
  parameter int unsigned PERIPH_BITS = 4,
  parameter int unsigned NPERIPH     = 9
) (
  input  logic [ADDRW-1:0]       addr_i,
  input  logic                   we_i,
  input  logic [NPERIPH-1:0]     rmask_i,
  input  logic [NPERIPH-1:0]     wmask_i,
  output logic                   is_periph_o,
  output logic [PERIPH_BITS-1:0] slot_o,
  output logic                   legal_o
);

  logic slot_ok;

  assign is_periph_o = &addr_i[ADDRW-1:PERIPH_BITS];
  assign slot_o      = addr_i[PERIPH_BITS-1:0];

  // Unimplemented slots never match, so they stay illegal.
  always_comb begin
    slot_ok = 1'b0;
    for (int i = 0; i < NPERIPH; i++) begin
      if (slot_o == PERIPH_BITS'(i))
        slot_ok = we_i ? wmask_i[i] : rmask_i[i];
    end
  end

  assign legal_o = !is_periph_o || slot_ok;

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU-side bus controller: SRAM with wait states plus a
// window of strobed peripheral slots at the top of memory.
import mem_bus_pkg::*;

module mem_bus_ctrl #(
  parameter int unsigned DATAW       = DEF_DATAW,
  parameter int unsigned ADDRW       = DEF_ADDRW,
  parameter int unsigned PERIPH_BITS = DEF_PERIPH_BITS,
  parameter int unsigned NPERIPH     = DEF_NPERIPH,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
  parameter logic [NPERIPH-1:0] PERIPH_RMASK = '1,
  parameter logic [NPERIPH-1:0] PERIPH_WMASK = '1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic                     we,
  input  logic [ADDRW-1:0]         addr,
  input  logic [DATAW-1:0]         wdata,
  output logic                     ack,
  output logic                     err,
  output logic [DATAW-1:0]         rdata,
  output logic                     busy,
  output logic                     sram_ce_n,
  output logic                     sram_oe_n,
  output logic                     sram_we_n,
  output logic [ADDRW-1:0]         sram_addr,
  output logic [DATAW-1:0]         sram_dout,
  output logic                     sram_dout_en,
  input  logic [DATAW-1:0]         sram_din,
  output logic [NPERIPH-1:0]       periph_sel,
  output logic                     periph_re,
  output logic                     periph_we,
  output logic [DATAW-1:0]         periph_wdata,
  input  logic [NPERIPH*DATAW-1:0] periph_rdata
);

  localparam logic [3:0] WS_L = 4'(WAIT_STATES);

  state_e                 state_q, state_d;
  logic [ADDRW-1:0]       addr_q, addr_d;
  logic                   we_q, we_d;
  logic [DATAW-1:0]       wdata_q, wdata_d;
  logic [PERIPH_BITS-1:0] slot_q, slot_d;
  logic                   err_q, err_d;
  logic [DATAW-1:0]       rdata_q, rdata_d;
  logic [3:0]             cnt_q, cnt_d;

  logic                   dec_periph;
  logic [PERIPH_BITS-1:0] dec_slot;
  logic                   dec_legal;
  logic [DATAW-1:0]       prd_mux;
  logic                   sram_on;

  mem_addr_decode #(
    .ADDRW      (ADDRW),
    .PERIPH_BITS(PERIPH_BITS),
    .NPERIPH    (NPERIPH)
  ) u_dec (
    .addr_i     (addr),
    .we_i       (we),
    .rmask_i    (PERIPH_RMASK),
    .wmask_i    (PERIPH_WMASK),
    .is_periph_o(dec_periph),
    .slot_o     (dec_slot),
    .legal_o    (dec_legal)
  );

  always_comb begin
    prd_mux = '0;
    for (int i = 0; i < NPERIPH; i++) begin
      if (slot_q == PERIPH_BITS'(i))
        prd_mux = periph_rdata[i*DATAW +: DATAW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      slot_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      slot_q  <= slot_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    slot_d  = slot_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr;
          we_d    = we;
          wdata_d = wdata;
          slot_d  = dec_slot;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          if (!dec_periph) begin
            state_d = SETUP;
          end else if (dec_legal) begin
            state_d = PERIPH;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == WS_L) begin
          state_d = DONE;
          if (!we_q)
            rdata_d = sram_din;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      PERIPH: begin
        state_d = DONE;
        if (!we_q)
          rdata_d = prd_mux;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sram_on      = (state_q == SETUP) || (state_q == ACCESS);
  assign sram_ce_n    = !sram_on;
  assign sram_oe_n    = !(sram_on && !we_q);
  assign sram_we_n    = !((state_q == ACCESS) && we_q);
  assign sram_dout_en = sram_on && we_q;
  assign sram_addr    = sram_on ? addr_q : '0;
  assign sram_dout    = sram_dout_en ? wdata_q : '0;

  always_comb begin
    periph_sel = '0;
    for (int i = 0; i < NPERIPH; i++)
      periph_sel[i] = (state_q == PERIPH) && (slot_q == PERIPH_BITS'(i));
  end

  assign periph_re    = (state_q == PERIPH) && !we_q;
  assign periph_we    = (state_q == PERIPH) && we_q;
  assign periph_wdata = periph_we ? wdata_q : '0;

  assign ack   = (state_q == DONE);
  assign err   = ack && err_q;
  assign rdata = rdata_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed vector bench for mem_bus_ctrl with a small SRAM model
// and fixed peripheral read values.
module tb_mem_bus_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic         we;
  logic [15:0]  addr;
  logic [15:0]  wdata;
  logic         ack, err, busy;
  logic [15:0]  rdata;
  logic         sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en;
  logic [15:0]  sram_addr, sram_dout, sram_din;
  logic [8:0]   periph_sel;
  logic         periph_re, periph_we;
  logic [15:0]  periph_wdata;
  logic [143:0] periph_rdata;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];

  always #5 clk = ~clk;

  mem_bus_ctrl #(
    .DATAW       (16),
    .ADDRW       (16),
    .PERIPH_BITS (4),
    .NPERIPH     (9),
    .WAIT_STATES (2),
    .PERIPH_RMASK(9'h1FF),
    .PERIPH_WMASK(9'h0F0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .ack         (ack),
    .err         (err),
    .rdata       (rdata),
    .busy        (busy),
    .sram_ce_n   (sram_ce_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n),
    .sram_addr   (sram_addr),
    .sram_dout   (sram_dout),
    .sram_dout_en(sram_dout_en),
    .sram_din    (sram_din),
    .periph_sel  (periph_sel),
    .periph_re   (periph_re),
    .periph_we   (periph_we),
    .periph_wdata(periph_wdata),
    .periph_rdata(periph_rdata)
  );

  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n)
      mem[sram_addr[7:0]] <= sram_dout;

  assign sram_din = mem[sram_addr[7:0]];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic        err;
    logic [15:0] rd;
    int          nce;
    int          nswe;
    int          nre;
    int          npwe;
    logic [8:0]  sel;
  } vec_t;

  vec_t v [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    int k, nce, nswe, nre, npwe;
    logic [8:0] sel;
    logic got;
    string s;
    s = $sformatf("v%0d", idx);
    nce = 0; nswe = 0; nre = 0; npwe = 0; sel = '0; got = 1'b0;
    @(negedge clk);
    req = 1'b1; we = t.we; addr = t.addr; wdata = t.wdata;
    k = 0;
    while (k < 20 && !got) begin
      @(negedge clk);
      if (!sram_ce_n) nce++;
      if (!sram_we_n) nswe++;
      if (periph_re) nre++;
      if (periph_we) npwe++;
      sel = sel | periph_sel;
      if (ack) begin
        got = 1'b1;
        chk({s, "_lat"}, 32'(k), 32'(t.lat));
        chk({s, "_err"}, {31'b0, err}, {31'b0, t.err});
        chk({s, "_rdata"}, {16'b0, rdata}, {16'b0, t.rd});
      end
      if (k == 0) begin
        req = 1'b0; addr = ~t.addr; wdata = ~t.wdata; we = ~t.we;
      end
      k++;
    end
    if (!got) chk({s, "_ack_timeout"}, 32'd0, 32'd1);
    chk({s, "_nce"}, 32'(nce), 32'(t.nce));
    chk({s, "_nswe"}, 32'(nswe), 32'(t.nswe));
    chk({s, "_nre"}, 32'(nre), 32'(t.nre));
    chk({s, "_npwe"}, 32'(npwe), 32'(t.npwe));
    chk({s, "_sel"}, {23'b0, sel}, {23'b0, t.sel});
  endtask

  task automatic chk_idle_outputs(input string s);
    chk({s, "_ack"}, {31'b0, ack}, 32'd0);
    chk({s, "_busy"}, {31'b0, busy}, 32'd0);
    chk({s, "_strb"},
        {26'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en,
         periph_re, periph_we}, 32'h38);
    chk({s, "_saddr"}, {16'b0, sram_addr}, 32'd0);
    chk({s, "_sdout"}, {16'b0, sram_dout}, 32'd0);
    chk({s, "_sel"}, {23'b0, periph_sel}, 32'd0);
  endtask

  initial begin
    int k;
    logic saw;
    logic [15:0] seq_a [4];
    int          seq_l [4];
    logic [15:0] seq_r [4];

    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 9; i++)
      periph_rdata[i*16 +: 16] = (i == 2) ? 16'h00A5 : 16'h1000 + 16'(i);

    v[0] = '{1'b1, 16'h0123, 16'hBEEF, 4, 1'b0, 16'h0000, 4, 3, 0, 0, 9'h000};
    v[1] = '{1'b0, 16'h0123, 16'h0000, 4, 1'b0, 16'hBEEF, 4, 0, 0, 0, 9'h000};
    v[2] = '{1'b1, 16'h0040, 16'h1234, 4, 1'b0, 16'h0000, 4, 3, 0, 0, 9'h000};
    v[3] = '{1'b0, 16'h0040, 16'h0000, 4, 1'b0, 16'h1234, 4, 0, 0, 0, 9'h000};
    v[4] = '{1'b0, 16'hFFF2, 16'h0000, 1, 1'b0, 16'h00A5, 0, 0, 1, 0, 9'h004};
    v[5] = '{1'b1, 16'hFFF5, 16'h5A5A, 1, 1'b0, 16'h0000, 0, 0, 0, 1, 9'h020};
    v[6] = '{1'b1, 16'hFFF0, 16'h7777, 0, 1'b1, 16'h0000, 0, 0, 0, 0, 9'h000};
    v[7] = '{1'b0, 16'hFFFC, 16'h0000, 0, 1'b1, 16'h0000, 0, 0, 0, 0, 9'h000};
    v[8] = '{1'b0, 16'hFFF8, 16'h0000, 1, 1'b0, 16'h1008, 0, 0, 1, 0, 9'h100};
    v[9] = '{1'b1, 16'hFFF9, 16'h1111, 0, 1'b1, 16'h0000, 0, 0, 0, 0, 9'h000};

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_rdata", {16'b0, rdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(v[i], i);

    // Back-to-back: req held high over alternating regions.
    seq_a = '{16'h0123, 16'hFFF2, 16'h0040, 16'hFFF8};
    seq_l = '{5, 2, 5, 2};
    seq_r = '{16'hBEEF, 16'h00A5, 16'h1234, 16'h1008};
    @(negedge clk);
    req = 1'b1; we = 1'b0;
    for (int j = 0; j < 4; j++) begin
      addr = seq_a[j];
      k = 0; saw = 1'b0;
      while (k < 20 && !saw) begin
        @(negedge clk);
        k++;
        saw = ack;
      end
      chk($sformatf("b2b%0d_lat", j), 32'(k), 32'(seq_l[j]));
      chk($sformatf("b2b%0d_rdata", j), {16'b0, rdata}, {16'b0, seq_r[j]});
      @(negedge clk);
      chk($sformatf("b2b%0d_gap", j), {30'b0, ack, busy}, 32'd0);
    end
    req = 1'b0;
    @(negedge clk);
    chk("b2b_stop", {31'b0, busy}, 32'd0);

    // Reset in the middle of an SRAM write's ACCESS phase.
    req = 1'b1; we = 1'b1; addr = 16'h0077; wdata = 16'h5555;
    k = 0; saw = 1'b0;
    while (k < 10 && !saw) begin
      @(negedge clk);
      req = 1'b0;
      saw = !sram_we_n;
      k++;
    end
    chk("rst_reach_access", {31'b0, saw}, 32'd1);
    #1 rst = 1'b1;
    #1 chk_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack) saw = 1'b1;
    end
    chk("midrst_noack", {31'b0, saw}, 32'd0);

    run_vec('{1'b1, 16'h0077, 16'hAAAA, 4, 1'b0, 16'h0000, 4, 3, 0, 0, 9'h000}, 10);
    run_vec('{1'b0, 16'h0077, 16'h0000, 4, 1'b0, 16'hAAAA, 4, 0, 0, 0, 9'h000}, 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
